// File: rtl/regfile_controller.sv
// Write-port owner for the register file: post-reset zero sweep, destination
// scoreboard with RAW/overflow stall, and round-robin arbitration of two writebacks.
module regfile_controller #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,

    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic              dec_use_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic              dec_use_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_writes_rd,
    output logic              dec_issue,
    output logic              dec_stall,

    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_rd,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,

    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_rd,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,

    output logic [ADDR_W-1:0] rf_addr_rd,
    output logic [DATA_W-1:0] rf_data_rd,
    output logic              rf_write_enable,
    output logic              sb_error
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_PEND = '1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
    logic [CNT_W-1:0]  pendCnt_q [NUM_REGS];
    logic [CNT_W-1:0]  pendCnt_d [NUM_REGS];
    logic              rrLast_q, rrLast_d;
    logic [ADDR_W-1:0] rfAddr_q, rfAddr_d;
    logic [DATA_W-1:0] rfData_q, rfData_d;
    logic              rfWe_q, rfWe_d;
    logic              sbError_q, sbError_d;

    logic              isRun;
    logic              rawHaz;
    logic              ovfHaz;
    logic              decIssue;
    logic              gnt0;
    logic              gnt1;
    logic              gntAny;
    logic [ADDR_W-1:0] gntRd;
    logic [DATA_W-1:0] gntData;

    assign isRun = (state_q == ST_RUN);

    // Hazards look only at the registered counts: a write granted this cycle does not unblock its readers yet.
    assign rawHaz = (dec_use_rs1 && (dec_rs1 != '0) && (pendCnt_q[dec_rs1] != '0)) ||
                    (dec_use_rs2 && (dec_rs2 != '0) && (pendCnt_q[dec_rs2] != '0));
    assign ovfHaz = dec_writes_rd && (dec_rd != '0) && (pendCnt_q[dec_rd] == MAX_PEND);

    assign decIssue = isRun && dec_valid && !rawHaz && !ovfHaz;

    // rrLast_q set means wb1 was granted most recently, so wb0 wins the next tie.
    assign gnt0    = isRun && wb0_valid && (!wb1_valid || rrLast_q);
    assign gnt1    = isRun && wb1_valid && (!wb0_valid || !rrLast_q);
    assign gntAny  = gnt0 || gnt1;
    assign gntRd   = gnt1 ? wb1_rd   : wb0_rd;
    assign gntData = gnt1 ? wb1_data : wb0_data;

    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        rrLast_d = rrLast_q;
        rfAddr_d = rfAddr_q;
        rfData_d = rfData_q;
        rfWe_d   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                rfWe_d   = 1'b1;
                rfAddr_d = clrIdx_q;
                rfData_d = '0;
                clrIdx_d = clrIdx_q + ADDR_W'(1);
                if (clrIdx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gntAny) begin
                    rrLast_d = gnt1;
                    if (gntRd != '0) begin
                        rfWe_d   = 1'b1;
                        rfAddr_d = gntRd;
                        rfData_d = gntData;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // A simultaneous issue and writeback to the same register cancel out.
    always_comb begin
        sbError_d = sbError_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            pendCnt_d[i] = pendCnt_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            logic incr;
            logic decr;
            incr = decIssue && dec_writes_rd && (dec_rd == ADDR_W'(i));
            decr = gntAny && (gntRd == ADDR_W'(i));
            if (decr && (pendCnt_q[i] == '0)) begin
                sbError_d = 1'b1;
            end
            if (incr && !decr) begin
                pendCnt_d[i] = pendCnt_q[i] + CNT_W'(1);
            end else if (decr && !incr && (pendCnt_q[i] != '0)) begin
                pendCnt_d[i] = pendCnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clrIdx_q  <= ADDR_W'(1);
            rrLast_q  <= 1'b1;
            rfAddr_q  <= '0;
            rfData_q  <= '0;
            rfWe_q    <= 1'b0;
            sbError_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pendCnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clrIdx_q  <= clrIdx_d;
            rrLast_q  <= rrLast_d;
            rfAddr_q  <= rfAddr_d;
            rfData_q  <= rfData_d;
            rfWe_q    <= rfWe_d;
            sbError_q <= sbError_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                pendCnt_q[i] <= pendCnt_d[i];
            end
        end
    end

    assign init_done       = isRun;
    assign dec_issue       = decIssue;
    assign dec_stall       = !isRun || (dec_valid && !decIssue);
    assign wb0_ready       = gnt0;
    assign wb1_ready       = gnt1;
    assign rf_addr_rd      = rfAddr_q;
    assign rf_data_rd      = rfData_q;
    assign rf_write_enable = rfWe_q;
    assign sb_error        = sbError_q;

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for regfile_controller: clear sweep, scoreboard stalls,
// writeback arbitration, rd=0 / sb_error handling and asynchronous reset.
module tb_regfile_controller;

    logic        clock;
    logic        reset_n;
    logic        init_done;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic        dec_use_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs2;
    logic [4:0]  dec_rd;
    logic        dec_writes_rd;
    logic        dec_issue;
    logic        dec_stall;
    logic        wb0_valid;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        rf_write_enable;
    logic        sb_error;

    int testsRun  = 0;
    int failCount = 0;

    regfile_controller dut (
        .clock(clock),
        .reset_n(reset_n),
        .init_done(init_done),
        .dec_valid(dec_valid),
        .dec_rs1(dec_rs1),
        .dec_use_rs1(dec_use_rs1),
        .dec_rs2(dec_rs2),
        .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd),
        .dec_writes_rd(dec_writes_rd),
        .dec_issue(dec_issue),
        .dec_stall(dec_stall),
        .wb0_valid(wb0_valid),
        .wb0_rd(wb0_rd),
        .wb0_data(wb0_data),
        .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid),
        .wb1_rd(wb1_rd),
        .wb1_data(wb1_data),
        .wb1_ready(wb1_ready),
        .rf_addr_rd(rf_addr_rd),
        .rf_data_rd(rf_data_rd),
        .rf_write_enable(rf_write_enable),
        .sb_error(sb_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyDec(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic wr);
        dec_valid     = v;
        dec_rs1       = rs1;
        dec_use_rs1   = u1;
        dec_rs2       = rs2;
        dec_use_rs2   = u2;
        dec_rd        = rd;
        dec_writes_rd = wr;
    endtask

    task automatic applyWb0(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb0_valid = v;
        wb0_rd    = rd;
        wb0_data  = d;
    endtask

    task automatic applyWb1(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb1_valid = v;
        wb1_rd    = rd;
        wb1_data  = d;
    endtask

    // Walks the clear sweep for 'upto' cycles; decode and wb0 are busy until index 5 to probe blocking.
    task automatic runSweep(input int upto);
        applyDec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        applyWb0(1'b1, 5'd6, 32'h55);
        for (int k = 1; k <= upto; k++) begin
            step();
            checkOutput("sweep_we", {31'd0, rf_write_enable}, 32'd1);
            checkOutput("sweep_addr", {27'd0, rf_addr_rd}, k);
            checkOutput("sweep_data", rf_data_rd, 32'd0);
            checkOutput("sweep_init", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            if (k == 5) begin
                checkOutput("clear_issue", {31'd0, dec_issue}, 32'd0);
                checkOutput("clear_stall", {31'd0, dec_stall}, 32'd1);
                checkOutput("clear_wb0_ready", {31'd0, wb0_ready}, 32'd0);
                applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
                applyWb0(1'b0, 5'd0, 32'd0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyWb0(1'b0, 5'd0, 32'd0);
        applyWb1(1'b0, 5'd0, 32'd0);
        step();
        step();
        checkOutput("rst_we", {31'd0, rf_write_enable}, 32'd0);
        checkOutput("rst_addr", {27'd0, rf_addr_rd}, 32'd0);
        checkOutput("rst_data", rf_data_rd, 32'd0);
        checkOutput("rst_init", {31'd0, init_done}, 32'd0);
        checkOutput("rst_sberr", {31'd0, sb_error}, 32'd0);
        checkOutput("rst_stall", {31'd0, dec_stall}, 32'd1);
        reset_n = 1'b1;

        // Test 1: full sweep then idle
        runSweep(31);
        step();
        checkOutput("idle_we", {31'd0, rf_write_enable}, 32'd0);
        checkOutput("idle_init", {31'd0, init_done}, 32'd1);
        checkOutput("idle_stall", {31'd0, dec_stall}, 32'd0);

        // Test 2: RAW stall on x5 released by wb0 grant
        applyDec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        checkOutput("t2_issue_rd5", {31'd0, dec_issue}, 32'd1);
        step();
        applyDec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("t2_raw_stall", {31'd0, dec_stall}, 32'd1);
        step();
        checkOutput("t2_raw_stall2", {31'd0, dec_stall}, 32'd1);
        applyWb0(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        checkOutput("t2_wb0_ready", {31'd0, wb0_ready}, 32'd1);
        checkOutput("t2_no_bypass", {31'd0, dec_stall}, 32'd1);
        step();
        applyWb0(1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("t2_rf_addr", {27'd0, rf_addr_rd}, 32'd5);
        checkOutput("t2_rf_data", rf_data_rd, 32'hDEADBEEF);
        checkOutput("t2_rf_we", {31'd0, rf_write_enable}, 32'd1);
        checkOutput("t2_stall_drop", {31'd0, dec_stall}, 32'd0);
        checkOutput("t2_issue", {31'd0, dec_issue}, 32'd1);
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();

        // Test 3: pend x10 x2, x11 x2, x12 x1; a lone wb1 grant makes wb0 win the first tie
        for (int n = 0; n < 5; n++) begin
            applyDec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, (n < 2) ? 5'd10 : ((n < 4) ? 5'd11 : 5'd12), 1'b1);
            #1;
            checkOutput("t3_issue", {31'd0, dec_issue}, 32'd1);
            step();
        end
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyWb1(1'b1, 5'd12, 32'h0C12);
        #1;
        checkOutput("t3_wb1_alone", {31'd0, wb1_ready}, 32'd1);
        step();
        applyWb0(1'b1, 5'd10, 32'hA0A0);
        applyWb1(1'b1, 5'd11, 32'hB1B1);
        for (int n = 0; n < 4; n++) begin
            #1;
            checkOutput("t3_ready0", {31'd0, wb0_ready}, (n % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("t3_ready1", {31'd0, wb1_ready}, (n % 2 == 0) ? 32'd0 : 32'd1);
            step();
            checkOutput("t3_rf_data", rf_data_rd, (n % 2 == 0) ? 32'hA0A0 : 32'hB1B1);
            checkOutput("t3_rf_addr", {27'd0, rf_addr_rd}, (n % 2 == 0) ? 32'd10 : 32'd11);
        end
        applyWb0(1'b0, 5'd0, 32'd0);
        applyWb1(1'b0, 5'd0, 32'd0);
        checkOutput("t3_sberr", {31'd0, sb_error}, 32'd0);

        // Test 4: overflow on fourth x7 destination
        applyDec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        for (int n = 0; n < 3; n++) begin
            #1;
            checkOutput("t4_issue", {31'd0, dec_issue}, 32'd1);
            step();
        end
        #1;
        checkOutput("t4_ovf_stall", {31'd0, dec_stall}, 32'd1);
        checkOutput("t4_ovf_issue", {31'd0, dec_issue}, 32'd0);
        step();
        applyWb0(1'b1, 5'd7, 32'h77);
        #1;
        checkOutput("t4_wb0_ready", {31'd0, wb0_ready}, 32'd1);
        checkOutput("t4_still_ovf", {31'd0, dec_issue}, 32'd0);
        step();
        applyWb0(1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("t4_issue_after", {31'd0, dec_issue}, 32'd1);
        checkOutput("t4_rf_data", rf_data_rd, 32'h77);
        step();
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Test 5: writeback to x0 is consumed silently; unmatched x9 write flags sb_error
        applyWb1(1'b1, 5'd0, 32'h1234);
        #1;
        checkOutput("t5_wb1_ready", {31'd0, wb1_ready}, 32'd1);
        step();
        applyWb1(1'b0, 5'd0, 32'd0);
        checkOutput("t5_x0_we", {31'd0, rf_write_enable}, 32'd0);
        checkOutput("t5_x0_sberr", {31'd0, sb_error}, 32'd0);
        applyWb0(1'b1, 5'd9, 32'h99);
        #1;
        checkOutput("t5_wb0_ready", {31'd0, wb0_ready}, 32'd1);
        step();
        applyWb0(1'b0, 5'd0, 32'd0);
        checkOutput("t5_x9_we", {31'd0, rf_write_enable}, 32'd1);
        checkOutput("t5_x9_addr", {27'd0, rf_addr_rd}, 32'd9);
        checkOutput("t5_x9_data", rf_data_rd, 32'h99);
        checkOutput("t5_sberr", {31'd0, sb_error}, 32'd1);
        step();
        checkOutput("t5_sberr_sticky", {31'd0, sb_error}, 32'd1);
        checkOutput("t5_idle_we", {31'd0, rf_write_enable}, 32'd0);

        // Test 6: reset mid-RUN with cnt[3]=2, then reset at sweep index 12
        applyDec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        step();
        step();
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_we", {31'd0, rf_write_enable}, 32'd0);
        checkOutput("t6_rst_addr", {27'd0, rf_addr_rd}, 32'd0);
        checkOutput("t6_rst_init", {31'd0, init_done}, 32'd0);
        checkOutput("t6_rst_sberr", {31'd0, sb_error}, 32'd0);
        checkOutput("t6_rst_stall", {31'd0, dec_stall}, 32'd1);
        reset_n = 1'b1;
        runSweep(12);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_mid_we", {31'd0, rf_write_enable}, 32'd0);
        checkOutput("t6_mid_addr", {27'd0, rf_addr_rd}, 32'd0);
        reset_n = 1'b1;
        runSweep(31);
        step();
        checkOutput("t6_idle_we", {31'd0, rf_write_enable}, 32'd0);
        applyDec(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1);
        #1;
        checkOutput("t6_counts_clear", {31'd0, dec_issue}, 32'd1);
        applyDec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
